// File: rtl/obi_hetic_mt.sv
// Multi-target HETI interrupt controller: per-line gateway, per-target arbiter and claim/ack,
// configured through an OBI subordinate. Optional input synchronizer: define HETIC_SYNC_EN.
module obi_hetic_mt #(
    parameter int unsigned NrIrqLines = 64,
    parameter int unsigned NrIrqPrios = 32,
    parameter int unsigned NrTargets  = 2
) (
    input  logic                                     clk_i,
    input  logic                                     rst_i,
    input  logic                                     obi_req_i,
    output logic                                     obi_gnt_o,
    input  logic [31:0]                              obi_addr_i,
    input  logic                                     obi_we_i,
    input  logic [3:0]                               obi_be_i,
    input  logic [31:0]                              obi_wdata_i,
    output logic                                     obi_rvalid_o,
    output logic [31:0]                              obi_rdata_o,
    output logic                                     obi_err_o,
    input  logic [NrIrqLines-1:0]                    ext_irqs_i,
    output logic [NrTargets-1:0]                     irq_valid_o,
    output logic [NrTargets*$clog2(NrIrqLines)-1:0]  irq_id_o,
    output logic [NrTargets*$clog2(NrIrqPrios)-1:0]  irq_level_o,
    output logic [NrTargets-1:0]                     irq_heti_o,
    output logic [NrTargets-1:0]                     irq_nest_o,
    input  logic [NrTargets-1:0]                     irq_ack_i,
    input  logic [NrTargets*$clog2(NrIrqLines)-1:0]  irq_ack_id_i
);

    localparam int unsigned IrqWidth  = $clog2(NrIrqLines);
    localparam int unsigned PrioWidth = $clog2(NrIrqPrios);
    localparam int unsigned TgtWidth  = (NrTargets > 1) ? $clog2(NrTargets) : 1;
    localparam logic [31:0] ThrBase   = 32'h0000_0400;

    // ---------------------------------------------------------------------------------------
    // Input conditioning
    // ---------------------------------------------------------------------------------------
    logic [NrIrqLines-1:0] irq_in;

`ifdef HETIC_SYNC_EN
    logic [NrIrqLines-1:0] sync1_q, sync2_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= ext_irqs_i;
            sync2_q <= sync1_q;
        end
    end

    assign irq_in = sync2_q;
`else
    assign irq_in = ext_irqs_i;
`endif

    // ---------------------------------------------------------------------------------------
    // State
    // ---------------------------------------------------------------------------------------
    logic [NrIrqLines-1:0] ie_q, ie_d, ip_q, ip_d, heti_q, heti_d, nest_q, nest_d, hist_q;
    logic [1:0]            trig_q [NrIrqLines];
    logic [1:0]            trig_d [NrIrqLines];
    logic [PrioWidth-1:0]  prio_q [NrIrqLines];
    logic [PrioWidth-1:0]  prio_d [NrIrqLines];
    logic [TgtWidth-1:0]   tgt_q  [NrIrqLines];
    logic [TgtWidth-1:0]   tgt_d  [NrIrqLines];
    logic [PrioWidth-1:0]  thr_q  [NrTargets];
    logic [PrioWidth-1:0]  thr_d  [NrTargets];

    // ---------------------------------------------------------------------------------------
    // Address decode
    // ---------------------------------------------------------------------------------------
    logic [31:0]          word_idx, thr_off;
    logic                 line_hit, thr_hit, wr_line, wr_thr;
    logic [IrqWidth-1:0]  line_idx;
    logic [TgtWidth-1:0]  thr_idx;

    assign word_idx = {20'd0, obi_addr_i[13:2]};
    assign thr_off  = word_idx - ThrBase;
    assign line_hit = word_idx < NrIrqLines;
    assign thr_hit  = (word_idx >= ThrBase) && (thr_off < NrTargets);
    assign line_idx = word_idx[IrqWidth-1:0];
    assign thr_idx  = thr_off[TgtWidth-1:0];
    assign wr_line  = obi_req_i & obi_we_i & line_hit;
    assign wr_thr   = obi_req_i & obi_we_i & thr_hit;

    logic unused_bits;
    assign unused_bits = ^{obi_addr_i[31:14], obi_addr_i[1:0], obi_wdata_i, obi_be_i[3]};

    // ---------------------------------------------------------------------------------------
    // OBI response
    // ---------------------------------------------------------------------------------------
    logic [31:0] rdata_d, rdata_q;
    logic        rvalid_q, err_q;

    always_comb begin
        rdata_d = '0;
        if (obi_req_i && !obi_we_i) begin
            if (line_hit) begin
                rdata_d[0]                 = ie_q[line_idx];
                rdata_d[1]                 = ip_q[line_idx];
                rdata_d[3:2]               = trig_q[line_idx];
                rdata_d[4]                 = heti_q[line_idx];
                rdata_d[5]                 = nest_q[line_idx];
                rdata_d[8 +: PrioWidth]    = prio_q[line_idx];
                rdata_d[16 +: TgtWidth]    = tgt_q[line_idx];
            end else if (thr_hit) begin
                rdata_d[PrioWidth-1:0]     = thr_q[thr_idx];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            rvalid_q <= obi_req_i;
            rdata_q  <= rdata_d;
            err_q    <= obi_req_i & ~(line_hit | thr_hit);
        end
    end

    assign obi_gnt_o    = obi_req_i;
    assign obi_rvalid_o = rvalid_q;
    assign obi_rdata_o  = rdata_q;
    assign obi_err_o    = err_q;

    // ---------------------------------------------------------------------------------------
    // Claim/ack: only the target a line is routed to may clear it
    // ---------------------------------------------------------------------------------------
    logic [NrTargets-1:0]  ack_ok;
    logic [NrIrqLines-1:0] ack_clr;

    always_comb begin
        logic [IrqWidth-1:0] ack_id;
        ack_id  = '0;
        ack_ok  = '0;
        ack_clr = '0;
        for (int t = 0; t < NrTargets; t++) begin
            ack_id = irq_ack_id_i[t*IrqWidth +: IrqWidth];
            if (irq_ack_i[t] && (32'(ack_id) < NrIrqLines) &&
                (tgt_q[ack_id] == TgtWidth'(t))) begin
                ack_ok[t]       = 1'b1;
                ack_clr[ack_id] = 1'b1;
            end
        end
    end

    // ---------------------------------------------------------------------------------------
    // Gateway
    // ---------------------------------------------------------------------------------------
    logic [NrIrqLines-1:0] gw_set;

    always_comb begin
        gw_set = '0;
        for (int i = 0; i < NrIrqLines; i++) begin
            case (trig_q[i])
                2'b00:   gw_set[i] = irq_in[i];
                2'b10:   gw_set[i] = ~irq_in[i];
                2'b01:   gw_set[i] = irq_in[i] & ~hist_q[i];
                default: gw_set[i] = ~irq_in[i] & hist_q[i];
            endcase
        end
    end

    // ---------------------------------------------------------------------------------------
    // Register next state; ip precedence is ack clear > gateway set > software write
    // ---------------------------------------------------------------------------------------
    always_comb begin
        ie_d   = ie_q;
        ip_d   = ip_q;
        heti_d = heti_q;
        nest_d = nest_q;
        trig_d = trig_q;
        prio_d = prio_q;
        tgt_d  = tgt_q;
        thr_d  = thr_q;
        if (wr_line) begin
            if (obi_be_i[0]) begin
                ie_d[line_idx]   = obi_wdata_i[0];
                ip_d[line_idx]   = obi_wdata_i[1];
                trig_d[line_idx] = obi_wdata_i[3:2];
                heti_d[line_idx] = obi_wdata_i[4];
                nest_d[line_idx] = obi_wdata_i[5];
            end
            if (obi_be_i[1]) prio_d[line_idx] = obi_wdata_i[8 +: PrioWidth];
            if (obi_be_i[2]) tgt_d[line_idx]  = obi_wdata_i[16 +: TgtWidth];
        end
        if (wr_thr && obi_be_i[0]) thr_d[thr_idx] = obi_wdata_i[PrioWidth-1:0];
        ip_d = (ip_d | gw_set) & ~ack_clr;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ie_q   <= '0;
            ip_q   <= '0;
            heti_q <= '0;
            nest_q <= '0;
            hist_q <= '0;
            trig_q <= '{default: '0};
            prio_q <= '{default: '0};
            tgt_q  <= '{default: '0};
            thr_q  <= '{default: '0};
        end else begin
            ie_q   <= ie_d;
            ip_q   <= ip_d;
            heti_q <= heti_d;
            nest_q <= nest_d;
            hist_q <= irq_in;
            trig_q <= trig_d;
            prio_q <= prio_d;
            tgt_q  <= tgt_d;
            thr_q  <= thr_d;
        end
    end

    // ---------------------------------------------------------------------------------------
    // Arbitration: highest priority wins, ascending scan with strict compare keeps lowest index
    // ---------------------------------------------------------------------------------------
    logic [NrTargets-1:0]           valid_d, valid_q, heti_o_d, heti_o_q, nest_o_d, nest_o_q;
    logic [NrTargets*IrqWidth-1:0]  id_d, id_q;
    logic [NrTargets*PrioWidth-1:0] level_d, level_q;

    always_comb begin
        logic                 found;
        logic [PrioWidth-1:0] best_prio;
        logic [IrqWidth-1:0]  best_id;
        found     = 1'b0;
        best_prio = '0;
        best_id   = '0;
        valid_d   = '0;
        heti_o_d  = '0;
        nest_o_d  = '0;
        id_d      = '0;
        level_d   = '0;
        for (int t = 0; t < NrTargets; t++) begin
            found     = 1'b0;
            best_prio = '0;
            best_id   = '0;
            for (int i = 0; i < NrIrqLines; i++) begin
                if (ie_q[i] && ip_q[i] && (tgt_q[i] == TgtWidth'(t)) &&
                    (prio_q[i] > thr_q[t])) begin
                    if (!found || (prio_q[i] > best_prio)) begin
                        found     = 1'b1;
                        best_prio = prio_q[i];
                        best_id   = IrqWidth'(i);
                    end
                end
            end
            // The claimed line is still visible in state this cycle; hide it for one cycle.
            valid_d[t]                        = found & ~ack_ok[t];
            id_d[t*IrqWidth +: IrqWidth]      = best_id;
            level_d[t*PrioWidth +: PrioWidth] = best_prio;
            heti_o_d[t]                       = found & heti_q[best_id];
            nest_o_d[t]                       = found & nest_q[best_id];
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_q  <= '0;
            id_q     <= '0;
            level_q  <= '0;
            heti_o_q <= '0;
            nest_o_q <= '0;
        end else begin
            valid_q  <= valid_d;
            id_q     <= id_d;
            level_q  <= level_d;
            heti_o_q <= heti_o_d;
            nest_o_q <= nest_o_d;
        end
    end

    assign irq_valid_o = valid_q;
    assign irq_id_o    = id_q;
    assign irq_level_o = level_q;
    assign irq_heti_o  = heti_o_q;
    assign irq_nest_o  = nest_o_q;

endmodule

// File: tb/tb_obi_hetic_mt.sv
// Randomized bench for obi_hetic_mt against a cycle-level behavioural model of the
// register map, gateway, routing and claim rules.
module tb_obi_hetic_mt;

    localparam int NL = 64;
    localparam int NP = 32;
    localparam int NT = 2;
    localparam int IW = 6;
    localparam int PW = 5;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst = 1'b1;
    logic              req = 1'b0, we = 1'b0;
    logic [31:0]       addr = '0, wdata = '0;
    logic [3:0]        be = '0;
    logic [NL-1:0]     ext = '0;
    logic [NT-1:0]     ack = '0;
    logic [NT*IW-1:0]  ack_id = '0;
    logic              gnt, rvalid, err;
    logic [31:0]       rdata;
    logic [NT-1:0]     irq_valid, irq_heti, irq_nest;
    logic [NT*IW-1:0]  irq_id;
    logic [NT*PW-1:0]  irq_level;

    obi_hetic_mt #(
        .NrIrqLines (NL),
        .NrIrqPrios (NP),
        .NrTargets  (NT)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .obi_req_i    (req),
        .obi_gnt_o    (gnt),
        .obi_addr_i   (addr),
        .obi_we_i     (we),
        .obi_be_i     (be),
        .obi_wdata_i  (wdata),
        .obi_rvalid_o (rvalid),
        .obi_rdata_o  (rdata),
        .obi_err_o    (err),
        .ext_irqs_i   (ext),
        .irq_valid_o  (irq_valid),
        .irq_id_o     (irq_id),
        .irq_level_o  (irq_level),
        .irq_heti_o   (irq_heti),
        .irq_nest_o   (irq_nest),
        .irq_ack_i    (ack),
        .irq_ack_id_i (ack_id)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model state
    bit [NL-1:0] m_ie, m_ip, m_heti, m_nest, m_hist, m_s1, m_s2;
    int          m_trig [NL];
    int          m_prio [NL];
    int          m_tgt  [NL];
    int          m_thr  [NT];

    // Expected registered outputs after the next clock edge
    bit          e_rvalid, e_err;
    logic [31:0] e_rdata;
    bit          e_valid [NT];
    bit          e_heti  [NT];
    bit          e_nest  [NT];
    int          e_id    [NT];
    int          e_level [NT];

    task automatic model_step();
        int          word, rd, best;
        int          aid [NT];
        bit          ok_line, ok_thr;
        bit [NL-1:0] src, gw;
        bit [NT-1:0] acc;
        if (rst) begin
            m_ie = '0; m_ip = '0; m_heti = '0; m_nest = '0;
            m_hist = '0; m_s1 = '0; m_s2 = '0;
            for (int i = 0; i < NL; i++) begin
                m_trig[i] = 0; m_prio[i] = 0; m_tgt[i] = 0;
            end
            for (int t = 0; t < NT; t++) begin
                m_thr[t] = 0; e_valid[t] = 0; e_heti[t] = 0; e_nest[t] = 0;
                e_id[t] = 0; e_level[t] = 0;
            end
            e_rvalid = 0; e_err = 0; e_rdata = '0;
            return;
        end

        word    = int'(addr[13:2]);
        ok_line = word < NL;
        ok_thr  = (word >= 1024) && (word < 1024 + NT);
        rd      = 0;
        if (ok_line)
            rd = int'(m_ie[word]) + 2 * int'(m_ip[word]) + 4 * m_trig[word] +
                 16 * int'(m_heti[word]) + 32 * int'(m_nest[word]) +
                 256 * m_prio[word] + 65536 * m_tgt[word];
        else if (ok_thr)
            rd = m_thr[word - 1024];
        e_rvalid = req;
        e_err    = req && !(ok_line || ok_thr);
        e_rdata  = (req && !we && (ok_line || ok_thr)) ? 32'(rd) : 32'd0;

        for (int t = 0; t < NT; t++) begin
            aid[t] = int'(ack_id[t*IW +: IW]);
            acc[t] = ack[t] && (m_tgt[aid[t]] == t);
        end

        for (int t = 0; t < NT; t++) begin
            best = -1;
            for (int i = 0; i < NL; i++)
                if (m_ie[i] && m_ip[i] && m_tgt[i] == t && m_prio[i] > m_thr[t])
                    if (best < 0 || m_prio[i] > m_prio[best]) best = i;
            e_valid[t] = (best >= 0) && !acc[t];
            e_id[t]    = (best >= 0) ? best : 0;
            e_level[t] = (best >= 0) ? m_prio[best] : 0;
            e_heti[t]  = (best >= 0) ? m_heti[best] : 0;
            e_nest[t]  = (best >= 0) ? m_nest[best] : 0;
        end

`ifdef HETIC_SYNC_EN
        src = m_s2;
`else
        src = ext;
`endif
        for (int i = 0; i < NL; i++) begin
            case (m_trig[i])
                0:       gw[i] = src[i];
                1:       gw[i] = src[i] && !m_hist[i];
                2:       gw[i] = !src[i];
                default: gw[i] = !src[i] && m_hist[i];
            endcase
        end

        if (req && we && ok_line) begin
            if (be[0]) begin
                m_ie[word]   = wdata[0];
                m_ip[word]   = wdata[1];
                m_trig[word] = int'(wdata[3:2]);
                m_heti[word] = wdata[4];
                m_nest[word] = wdata[5];
            end
            if (be[1]) m_prio[word] = int'(wdata[15:8]) % NP;
            if (be[2]) m_tgt[word]  = int'(wdata[23:16]) % 2;
        end
        if (req && we && ok_thr && be[0]) m_thr[word - 1024] = int'(wdata[7:0]) % NP;

        m_ip = m_ip | gw;
        for (int t = 0; t < NT; t++) if (acc[t]) m_ip[aid[t]] = 1'b0;
        m_hist = src;
        m_s2   = m_s1;
        m_s1   = ext;
    endtask

    task automatic cycle();
        #1;
        check_eq("gnt", 32'(gnt), 32'(req));
        model_step();
        @(posedge clk);
        #1;
        check_eq("rvalid", 32'(rvalid), 32'(e_rvalid));
        check_eq("rdata", rdata, e_rdata);
        check_eq("err", 32'(err), 32'(e_err));
        for (int t = 0; t < NT; t++) begin
            check_eq($sformatf("valid[%0d]", t), 32'(irq_valid[t]), 32'(e_valid[t]));
            if (e_valid[t]) begin
                check_eq($sformatf("id[%0d]", t), 32'(irq_id[t*IW +: IW]), 32'(e_id[t]));
                check_eq($sformatf("level[%0d]", t), 32'(irq_level[t*PW +: PW]),
                         32'(e_level[t]));
                check_eq($sformatf("heti[%0d]", t), 32'(irq_heti[t]), 32'(e_heti[t]));
                check_eq($sformatf("nest[%0d]", t), 32'(irq_nest[t]), 32'(e_nest[t]));
            end
        end
    endtask

    task automatic idle(input int n);
        req = 0; we = 0; ack = '0;
        repeat (n) cycle();
    endtask

    task automatic obi(input bit w, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] b);
        req = 1; we = w; addr = a; wdata = d; be = b;
        cycle();
        req = 0; we = 0;
    endtask

    task automatic do_ack(input int t, input int id);
        ack = '0;
        ack[t] = 1'b1;
        ack_id[t*IW +: IW] = IW'(id);
        cycle();
        ack = '0;
    endtask

    initial begin
        int r;
        rst = 1;
        idle(2);
        check_eq("rst_valid", 32'(irq_valid), 32'd0);
        check_eq("rst_id", 32'(irq_id), 32'd0);
        check_eq("rst_level", 32'(irq_level), 32'd0);
        check_eq("rst_heti", 32'(irq_heti), 32'd0);
        check_eq("rst_nest", 32'(irq_nest), 32'd0);
        check_eq("rst_rvalid", 32'(rvalid), 32'd0);
        rst = 0;
        idle(1);

        // line 2: ie, ip, prio 5, target 0; then read it back
        obi(1, 32'h008, 32'h0000_0503, 4'hF);
        idle(2);
        obi(0, 32'h008, 32'h0, 4'hF);
        idle(1);

        // lines 3 and 7: rising edge, prio 9, target 1; equal prio -> lowest id first
        obi(1, 32'h00C, 32'h0001_0905, 4'hF);
        obi(1, 32'h01C, 32'h0001_0905, 4'hF);
        ext[3] = 1; ext[7] = 1;
        idle(1);
        ext[3] = 0; ext[7] = 0;
        idle(4);
        do_ack(1, 3);
        idle(3);

        // threshold masks equal priority, raised priority passes
        obi(1, 32'h1000, 32'h0000_0005, 4'hF);
        idle(2);
        obi(1, 32'h008, 32'h0000_0600, 4'b0010);
        idle(2);

        // active-low level line 10 held asserted: ack clears, gateway re-pends
        obi(1, 32'h028, 32'h0000_0309, 4'hF);
        idle(3);
        do_ack(0, 10);
        obi(0, 32'h028, 32'h0, 4'hF);
        obi(0, 32'h028, 32'h0, 4'hF);

        // foreign ack ignored; unmapped address errors
        do_ack(1, 2);
        idle(1);
        obi(0, 32'h2000, 32'h0, 4'hF);
        obi(1, 32'h2000, 32'hFFFF_FFFF, 4'hF);
        obi(0, 32'h1008, 32'h0, 4'hF);
        idle(1);

        // edge latency on line 0, observed through back-to-back reads
        obi(1, 32'h000, 32'h0000_0105, 4'hF);
        idle(1);
        ext[0] = 1;
        repeat (5) obi(0, 32'h000, 32'h0, 4'hF);
        idle(1);

        // randomized traffic with a reset mid-transaction
        for (int c = 0; c < 3000; c++) begin
            ext ^= {$urandom, $urandom} & {$urandom, $urandom} & {$urandom, $urandom};
            req = 1'($urandom_range(0, 1));
            we  = 1'($urandom_range(0, 1));
            r   = $urandom_range(0, 9);
            if (r < 8)       addr = 32'($urandom_range(0, NL - 1)) << 2;
            else if (r == 8) addr = 32'h1000 + 32'(4 * $urandom_range(0, NT - 1));
            else             addr = $urandom;
            wdata = $urandom;
            be    = 4'($urandom);
            for (int t = 0; t < NT; t++) begin
                ack[t] = ($urandom_range(0, 3) == 0);
                if (e_valid[t] && $urandom_range(0, 3) != 0) ack_id[t*IW +: IW] = IW'(e_id[t]);
                else ack_id[t*IW +: IW] = IW'($urandom_range(0, NL - 1));
            end
            rst = (c == 1500);
            cycle();
        end
        rst = 0;
        idle(3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/obi_hetic_mt.md
Name: obi_hetic_mt

Overview:
Multi-target successor of the HETI interrupt controller. Routes NrIrqLines external interrupts to NrTargets cores (harts), each with its own priority threshold, arbiter and claim/ack handshake. Configured over an OBI subordinate port. Sits between the external interrupt sources and the per-core HETI interrupt inputs.

Parameters:
NrIrqLines, 64, number of interrupt lines (2..1024)
NrIrqPrios, 32, number of priority levels (2..256)
NrTargets, 2, number of interrupt targets (1..256)
IrqWidth, $clog2(NrIrqLines), localparam, line ID width
PrioWidth, $clog2(NrIrqPrios), localparam, priority width
TgtWidth, max(1,$clog2(NrTargets)), localparam, target field width

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous active-high reset
obi_req_i  in  1  OBI request
obi_gnt_o  out  1  OBI grant; equals obi_req_i
obi_addr_i  in  32  byte address
obi_we_i  in  1  write enable
obi_be_i  in  4  byte enables
obi_wdata_i  in  32  write data
obi_rvalid_o  out  1  response valid
obi_rdata_o  out  32  read data
obi_err_o  out  1  response error
ext_irqs_i  in  NrIrqLines  raw interrupt inputs
irq_valid_o  out  NrTargets  per-target interrupt request
irq_id_o  out  NrTargets*IrqWidth  per-target winning line
irq_level_o  out  NrTargets*PrioWidth  per-target winning priority
irq_heti_o  out  NrTargets  heti bit of winning line
irq_nest_o  out  NrTargets  nest bit of winning line
irq_ack_i  in  NrTargets  per-target claim strobe
irq_ack_id_i  in  NrTargets*IrqWidth  line claimed by target

Behaviour:
- Reset: every line field, every threshold, edge history, rdata, rvalid, err and all irq_* outputs = 0.
- Register map, word index = addr[13:2]:
  - 0x000+4*i, i<NrIrqLines, line i: [0] ie, [1] ip, [3:2] trig, [4] heti, [5] nest, [15:8] prio (low PrioWidth bits), [23:16] target (low TgtWidth bits). Unused bits read 0.
  - 0x1000+4*t, t<NrTargets, threshold[t] in [7:0] (low PrioWidth bits).
  - Any other address: writes ignored, reads return 0, err=1.
- Byte enables are honoured per byte. A field is updated only when its byte is enabled.
- OBI: gnt = req. rvalid, rdata and err are registered and appear exactly 1 cycle after req. Writes also get an rvalid response with rdata = 0. Read data reflects the state before any same-cycle update.
- Gateway, per line:
  - trig[0]=0 selects level mode. ip is set every cycle the input equals the active level (trig[1]=0 high, 1 low).
  - trig[0]=1 selects edge mode. ip is set on a rising edge (trig[1]=0) or falling edge (trig[1]=1) versus the previous-cycle sample. The history register updates every cycle.
- Precedence for ip in one cycle: ack clear > gateway set > software write.
- Eligibility: line i is eligible for target t when ie & ip & (target==t) & (prio > threshold[t]). A target value >= NrTargets is never routed.
- Arbitration per target: highest prio wins; ties go to the lowest index. All irq_* outputs are registered, so they reflect the state 1 cycle later (state change -> output change = 1 cycle).
- Ack:
  - irq_ack_i[t] with id clears that line's ip only if its target==t. Otherwise the ack is ignored.
  - irq_valid_o[t] is forced 0 in the cycle after an accepted ack on t, so a stale ID cannot be claimed twice.
- Simultaneous acks from different targets on different lines are all honoured.
- A level-mode line still asserted after ack re-pends next cycle.
- Reset mid-transaction: the pending rvalid is dropped and the state clears.

Optional Feature:
HETIC_SYNC_EN
- Defined: ext_irqs_i passes through a 2-flop synchronizer (reset 0) before the gateway, adding 2 cycles of input-to-ip latency. Edge history is taken on the synchronized value.
- Undefined: inputs are sampled directly, and ip is set the cycle after the input event.

Test Plan:
- Write 0x0000_0503 to 0x008 (line 2: ie=1, ip=1, prio=5, target 0) -> irq_valid_o[0]=1, id=2, level=5 two cycles later. A read of 0x008 returns 0x0000_0503 with rvalid 1 cycle after req.
- Lines 3 and 7, both prio 9 and target 1; pulse ext_irqs_i[3] and [7] (rising edge mode) -> target 1 presents id 3. Ack id 3 -> valid low 1 cycle, then id 7.
- Set threshold[0]=5 at 0x1000 with line 2 prio 5 pending -> irq_valid_o[0]=0. Raise prio to 6 -> valid returns.
- Active-low level line: hold input 0, ack in the same cycle as gateway set -> ip clears, then re-pends the next cycle.
- Target 1 acks a line routed to target 0 -> ip unchanged. A read of 0x2000 -> rdata=0, err=1.
- With HETIC_SYNC_EN defined, an edge on ext_irqs_i[0] -> ip set 3 cycles later (versus 1 without).
